// File: rtl/pc_sequencer_pkg.sv
// Shared types and constants for the fetch sequencer: FSM state encoding,
// the sequential increment and the redirect-select bundle.
package pc_sequencer_pkg;

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2,
    S_DRAIN = 2'd3
  } pcs_state_t;

  localparam int          PC_INC    = 4;
  localparam logic [31:0] WORD_ZERO = 32'h0;

  // Redirect requests from ID/EX; the mux resolves jr > jmp > br.
  typedef struct packed {
    logic jr;
    logic jmp;
    logic br;
  } redir_sel_t;

  function automatic logic any_redir(redir_sel_t s);
    return s.jr | s.jmp | s.br;
  endfunction

endpackage

// File: rtl/pc_sequencer_next_pc_mux.sv
// Combinational next-PC selection: sequential pc+INC or a word-aligned
// redirect target, with a misalign flag on the raw target.
module pc_sequencer_next_pc_mux
  import pc_sequencer_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int INC   = PC_INC
) (
  input  redir_sel_t       sel,
  input  logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] br_target,
  input  logic [WIDTH-1:0] jmp_target,
  input  logic [WIDTH-1:0] jr_target,
  output logic [WIDTH-1:0] pc_plus4,
  output logic [WIDTH-1:0] next_pc,
  output logic             redirect,
  output logic             misalign
);

  logic [WIDTH-1:0] tgt;

  // Wraps modulo 2^WIDTH by construction.
  assign pc_plus4 = pc + WIDTH'(INC);

  // Priority pick of the raw redirect target.
  always_comb begin
    tgt = pc_plus4;
    if (sel.jr)       tgt = jr_target;
    else if (sel.jmp) tgt = jmp_target;
    else if (sel.br)  tgt = br_target;
  end

  assign redirect = any_redir(sel);
  assign misalign = redirect & (tgt[1:0] != 2'b00);
  // Low bits are forced to zero so the PC is always word aligned.
  assign next_pc  = redirect ? {tgt[WIDTH-1:2], 2'b00} : pc_plus4;

endmodule

// File: rtl/pc_sequencer.sv
// Program counter and fetch sequencer: owns the PC, runs the imem req/ack
// handshake, honours hazard stalls and drains fetches squashed by redirects.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(WORD_ZERO),
  parameter int               INC      = PC_INC
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             br_taken,
  input  logic [WIDTH-1:0] br_target,
  input  logic             jmp,
  input  logic [WIDTH-1:0] jmp_target,
  input  logic             jr,
  input  logic [WIDTH-1:0] jr_target,
  input  logic             imem_ack,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus4,
  output logic             if_valid,
  output logic             flush,
  output logic             misalign
);

  pcs_state_t       state;
  redir_sel_t       sel;
  logic [WIDTH-1:0] next_pc;
  logic             redirect;
  logic             tgt_misalign;
  logic             redir_ok;

  assign sel = '{jr: jr, jmp: jmp, br: br_taken};

  pc_sequencer_next_pc_mux #(.WIDTH(WIDTH), .INC(INC)) u_mux (
    .sel        (sel),
    .pc         (pc),
    .br_target  (br_target),
    .jmp_target (jmp_target),
    .jr_target  (jr_target),
    .pc_plus4   (pc_plus4),
    .next_pc    (next_pc),
    .redirect   (redirect),
    .misalign   (tgt_misalign)
  );

  // Redirects are only acted on once the boot bubble is over.
  assign redir_ok  = redirect & (state != S_BOOT);
  assign flush     = redir_ok;
  assign misalign  = redir_ok & tgt_misalign;
  assign imem_addr = pc;

  // Word handed to IF/ID: a fresh ack, or the held word once stall drops.
  // A redirect always squashes, so flush and if_valid never coincide.
  always_comb begin
    if_valid = 1'b0;
    if (!redir_ok && !stall)
      if_valid = ((state == S_FETCH) && imem_ack) || (state == S_HOLD);
  end

  // Fetch FSM with the PC register and the registered imem request.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= RESET_PC;
      state    <= S_BOOT;
      imem_req <= 1'b0;
    end else begin
      case (state)
        S_BOOT: begin
          state    <= S_FETCH;
          imem_req <= 1'b1;
        end
        S_FETCH: begin
          if (redir_ok) begin
            pc <= next_pc;
            // Without ack the old fetch is still outstanding: drain it.
            if (!imem_ack) state <= S_DRAIN;
          end else if (imem_ack) begin
            if (stall) begin
              state    <= S_HOLD;
              imem_req <= 1'b0;
            end else begin
              pc <= pc_plus4;
            end
          end
        end
        S_HOLD: begin
          if (redir_ok) begin
            pc       <= next_pc;
            state    <= S_FETCH;
            imem_req <= 1'b1;
          end else if (!stall) begin
            pc       <= pc_plus4;
            state    <= S_FETCH;
            imem_req <= 1'b1;
          end
        end
        S_DRAIN: begin
          // The draining word is dropped; a newer redirect just moves pc.
          // Once acked nothing is outstanding, so fetch at the current pc.
          if (redir_ok) pc <= next_pc;
          if (imem_ack) state <= S_FETCH;
        end
        default: begin
          state    <= S_BOOT;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: stimulus pushes expected per-cycle
// outputs and expected fetch addresses; a monitor pops and compares.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst, stall, br_taken, jmp, jr, imem_ack;
  logic [31:0] br_target, jmp_target, jr_target;
  logic        imem_req, if_valid, flush, misalign;
  logic [31:0] imem_addr, pc, pc_plus4;

  pc_sequencer dut (
    .clk(clk), .rst(rst), .stall(stall),
    .br_taken(br_taken), .br_target(br_target),
    .jmp(jmp), .jmp_target(jmp_target),
    .jr(jr), .jr_target(jr_target),
    .imem_ack(imem_ack), .imem_req(imem_req), .imem_addr(imem_addr),
    .pc(pc), .pc_plus4(pc_plus4),
    .if_valid(if_valid), .flush(flush), .misalign(misalign)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        req;
    logic        iv;
    logic        fl;
    logic        mis;
  } exp_t;

  exp_t        cyc_q[$];
  logic [31:0] fetch_q[$];
  int          errors = 0;
  int          checks = 0;

  // Reference model: where the sequencer is, described as plain facts.
  logic [31:0] m_pc      = 32'h0;
  bit          m_booting = 1'b1;  // one idle cycle after reset
  bit          m_holding = 1'b0;  // fetched word parked in IF/ID
  bit          m_discard = 1'b0;  // outstanding fetch belongs to an old path

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input bit r, input bit st, input bit ack,
                     input bit b, input logic [31:0] bt,
                     input bit j, input logic [31:0] jt,
                     input bit jrr, input logic [31:0] jrt);
    exp_t        e;
    bit          redir;
    logic [31:0] tgt;
    @(negedge clk);
    rst = r; stall = st; imem_ack = ack;
    br_taken = b; br_target = bt; jmp = j; jmp_target = jt; jr = jrr; jr_target = jrt;
    tgt   = jrr ? jrt : (j ? jt : bt);
    redir = (jrr || j || b) && !m_booting;
    e.pc  = m_pc;
    e.req = !m_booting && !m_holding;
    e.fl  = redir;
    e.mis = redir && (tgt[1:0] != 2'b00);
    e.iv  = !redir && !st &&
            (m_holding || (!m_booting && !m_discard && ack));
    cyc_q.push_back(e);
    if (e.iv) fetch_q.push_back(m_pc);
    // Advance the model to the state after this clock edge.
    if (r) begin
      m_pc = 32'h0; m_booting = 1; m_holding = 0; m_discard = 0;
    end else if (m_booting) begin
      m_booting = 0;
    end else if (redir) begin
      m_pc = tgt & 32'hFFFF_FFFC;
      if (m_holding) m_holding = 0;
      else m_discard = !ack;
    end else if (m_holding) begin
      if (!st) begin m_pc = m_pc + 32'd4; m_holding = 0; end
    end else if (m_discard) begin
      if (ack) m_discard = 0;
    end else if (ack) begin
      if (st) m_holding = 1;
      else m_pc = m_pc + 32'd4;
    end
  endtask

  task automatic idle(input bit st, input bit ack);
    cyc(0, st, ack, 0, 32'h0, 0, 32'h0, 0, 32'h0);
  endtask

  // Sample settled registers shortly after an edge.
  task automatic peek(input string name, input logic [31:0] exp_pc, input logic exp_req);
    @(posedge clk); #2;
    chk({name, "_pc"}, pc, exp_pc);
    chk({name, "_req"}, {31'h0, imem_req}, {31'h0, exp_req});
  endtask

  // Monitor: compare every cycle's outputs just before the active edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk); #4;
      if (cyc_q.size() > 0) begin
        e = cyc_q.pop_front();
        chk("pc",        pc,        e.pc);
        chk("imem_addr", imem_addr, e.pc);
        chk("pc_plus4",  pc_plus4,  e.pc + 32'd4);
        chk("ctl", {28'h0, imem_req, if_valid, flush, misalign},
                   {28'h0, e.req, e.iv, e.fl, e.mis});
        if (if_valid) begin
          if (fetch_q.size() == 0) chk("fetch_unexpected", 32'h1, 32'h0);
          else chk("fetch_addr", imem_addr, fetch_q.pop_front());
        end
      end
    end
  end

  initial begin
    rst = 1; stall = 0; imem_ack = 0; br_taken = 0; jmp = 0; jr = 0;
    br_target = 0; jmp_target = 0; jr_target = 0;
    // Reset for two cycles, then one boot bubble.
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    peek("boot", 32'h0, 1'b0);
    idle(0, 0);
    peek("fetch0", 32'h0, 1'b1);
    // Sequential back-to-back fetches 0 -> 4 -> 8 -> 12.
    repeat (3) idle(0, 1);
    peek("seq", 32'd12, 1'b1);
    // Redirect to 8 coinciding with an ack: word dropped, stay fetching.
    cyc(0, 0, 1, 0, 0, 1, 32'h8, 0, 0);
    // Ack under stall at pc=8, hold three cycles, then release.
    idle(1, 1);
    idle(1, 0);
    idle(1, 0);
    peek("hold", 32'h8, 1'b0);
    idle(0, 0);
    peek("release", 32'd12, 1'b1);
    idle(0, 1);
    // jr 0x40 in flight at pc=16, ack two cycles later is discarded.
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 32'h40);
    idle(0, 0);
    idle(0, 1);
    peek("drain", 32'h40, 1'b1);
    idle(0, 1);
    // All three redirects at once: jr wins and is misaligned.
    cyc(0, 0, 0, 1, 32'h200, 1, 32'h100, 1, 32'h302);
    peek("prio", 32'h300, 1'b1);
    idle(0, 1);
    // Wrap from the top of the address space.
    cyc(0, 0, 1, 0, 0, 0, 0, 1, 32'hFFFF_FFFC);
    idle(0, 1);
    peek("wrap", 32'h0, 1'b1);
    // Reset while a fetch is outstanding; the late ack must be ignored.
    idle(0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(0, 1);
    peek("rst_mid", 32'h0, 1'b1);

    // Randomised traffic.
    for (int i = 0; i < 600; i++) begin
      logic [31:0] t0, t1, t2;
      t0 = $urandom; t1 = $urandom; t2 = $urandom;
      if ($urandom_range(0, 3) != 0) begin t0[1:0] = 0; t1[1:0] = 0; t2[1:0] = 0; end
      cyc($urandom_range(0, 99) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
          $urandom_range(0, 11) == 0, t0, $urandom_range(0, 15) == 0, t1,
          $urandom_range(0, 15) == 0, t2);
    end
    idle(0, 0);
    idle(0, 0);
    @(negedge clk); #6;
    chk("cyc_q_drained", cyc_q.size(), 0);
    chk("fetch_q_drained", fetch_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
